// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM state encoding for the data-memory arbiter.
// Build option DMEM_ARB_RR_EN (see dmem_arbiter.sv) does not affect this package.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_DEPTH = 4096;
    localparam int unsigned DMEM_ADDR_W     = $clog2(DMEM_ADDR_DEPTH);
    localparam int unsigned CPU_WIDTH       = 32;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbOwn0 = 2'd1,
        ArbOwn1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-input combinational priority picker: one-hot grant, ties resolved against 'last'.
// Holding last = 1 turns it into a fixed port-0-first picker.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and debug/loader (port 1).
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 wins every tie.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = CPU_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_lock,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e state_q, state_d;
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       last;
    logic       rd_pend_q;
    logic       rd_id_q;
    logic       rd_grant;

    arb_rr2 u_pick (
        .req  ({m1_req, m0_req}),
        .last (last),
        .gnt  (pick)
    );

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

    assign last = last_q;
`else
    assign last = 1'b1;
`endif

    // Owner state: only the locked port may be granted; dropping req releases without a grant.
    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        unique case (state_q)
            ArbIdle: begin
                gnt = pick;
                if (pick[0] && m0_lock) begin
                    state_d = ArbOwn0;
                end else if (pick[1] && m1_lock) begin
                    state_d = ArbOwn1;
                end
            end
            ArbOwn0: begin
                if (m0_req) begin
                    gnt = 2'b01;
                    if (!m0_lock) state_d = ArbIdle;
                end else begin
                    state_d = ArbIdle;
                end
            end
            ArbOwn1: begin
                if (m1_req) begin
                    gnt = 2'b10;
                    if (!m1_lock) state_d = ArbIdle;
                end else begin
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (gnt[0]) begin
            mem_ce    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_wstrb;
        end else if (gnt[1]) begin
            mem_ce    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
        end
    end

    assign rd_grant = mem_ce & ~mem_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ArbIdle;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_grant;
            if (rd_grant) begin
                rd_id_q <= gnt[1];
            end
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rd_pend_q & ~rd_id_q;
    assign m1_rvalid = rd_pend_q & rd_id_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port synchronous data memory between the core load/store unit (port 0) and the debug/loader port (port 1). It sits between `riscv` and the data memory inside `soc_top`, grants one access per cycle, routes registered read data back to the owner of the access, and supports a lock that keeps ownership across multi-beat transfers.

## Interface
- `ADDR_W`, 12, word-address width of the data memory.
- `DATA_W`, 32, data width; equals `CPU_WIDTH`.
- `clk  in  1  system clock.` All logic is on the rising edge.
- `rst_n  in  1  reset.` Synchronous, active-low.
- `mN_req  in  1  request from port N (N = 0, 1).` Held until granted.
- `mN_lock  in  1  keep ownership after this beat.` Sampled with `mN_req`.
- `mN_we  in  1  write enable.` 0 means read.
- `mN_addr  in  ADDR_W  word address.`
- `mN_wdata  in  DATA_W  write data.`
- `mN_wstrb  in  DATA_W/8  byte strobes.`
- `mN_gnt  out  1  access accepted this cycle.` Combinational.
- `mN_rvalid  out  1  read data valid.` Registered.
- `mN_rdata  out  DATA_W  read data.` Zero when `mN_rvalid` is 0.
- `mem_ce  out  1  memory access strobe.`
- `mem_we  out  1  memory write enable.`
- `mem_addr  out  ADDR_W  memory address.`
- `mem_wdata  out  DATA_W  memory write data.`
- `mem_wstrb  out  DATA_W/8  memory byte strobes.`
- `mem_rdata  in  DATA_W  memory read data.` Valid one cycle after `mem_ce & ~mem_we`.

## Operation
- FSM states: IDLE, OWN0, OWN1. Reset state is IDLE.
- IDLE: arbitrate among the active `mN_req`. The winner gets `mN_gnt = 1` and drives `mem_*`.
  - If the winner's `mN_lock` is 1, go to OWNN. Otherwise stay in IDLE.
- OWNN: only port N may be granted. The other port's `gnt` is 0 even if it requests.
  - Return to IDLE after a granted beat with `mN_lock = 0`.
  - Also return to IDLE on any cycle with `mN_req = 0`. No grant is issued that cycle.
- Priority pointer `last` (1 bit, reset 1) records the last granted port. On a tie in IDLE, grant port `~last`, so port 0 wins the first tie after reset.
- The read owner is registered on every granted read (`rd_pend <= 1`, `rd_id <= N`). The next cycle `mN_rvalid = (rd_id == N) & rd_pend` and `mN_rdata = mem_rdata`.
- Writes produce no `rvalid`.
- With no grant: `mem_ce = 0`, and `mem_addr`, `mem_wdata`, `mem_wstrb` are 0.
- Strobes pass through unchanged. There is no width conversion and no address offset.

## Timing
- Grant decision is combinational from `req`, state and `last` in the same cycle. Zero-cycle grant latency.
- Read data latency is exactly 1 cycle after grant. Back-to-back grants are allowed every cycle, from either port.
- Reset (synchronous, when `rst_n` is low at a clock edge) sets: state IDLE, `last = 1`, `rd_pend = 0`, all `gnt`/`rvalid` 0, `mem_ce` 0.
- Reset mid-operation: the pending read is dropped (no `rvalid`) and the lock is released.
- Simultaneous events:
  - Both ports request in IDLE: grant goes to the non-last port.
  - A read grant coincides with delivery of the previous read's data: both happen. The `rvalid` for the previous owner is unaffected by the new grant.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin tie-break using `last`, as described above.
- `DMEM_ARB_RR_EN` undefined: fixed priority. Port 0 (core) always wins ties in IDLE and the `last` register is not built. The lock and FSM are unchanged.

## Structure
- Shared package (`defines.v`):
  - `DMEM_ADDR_DEPTH`, from which `ADDR_W` is derived.
  - FSM state encodings `ARB_IDLE = 2'd0`, `ARB_OWN0 = 2'd1`, `ARB_OWN1 = 2'd2`.
  - `CPU_WIDTH`.
- One natural sub-module: `arb_rr2`, a 2-input combinational priority picker taking `req[1:0]` and `last` (or fixed priority) and producing a one-hot grant.
- FSM, read-owner tracking and mux stay in `dmem_arbiter`.

## Test plan
- Reset, then port 0 reads addr 0x010 with memory preloaded 0xDEADBEEF -> `m0_gnt = 1` in cycle 0; `m0_rvalid = 1` and `m0_rdata = 0xDEADBEEF` in cycle 1; `m1_rvalid` stays 0.
- Both ports request continuously, unlocked (RR build) -> grants alternate 0, 1, 0, 1. Fixed-priority build -> port 0 is granted every cycle.
- Port 1 writes 0x0000_00AA with `wstrb = 4'b0001` to addr 0x020 and holds `lock = 1` for 3 beats while port 0 requests -> port 0 gets no grant for those 3 beats. Port 0 is granted on the cycle after port 1's unlocked final beat. A readback shows only byte 0 changed.
- Port 0 read at cycle N, then port 1 read at N+1 -> `m0_rvalid` at N+1 and `m1_rvalid` at N+2, each with its own address's data.
- Port 1 locked read granted, `rst_n = 0` on the next edge -> no `m1_rvalid`, state returns to IDLE, and the first post-reset tie grants port 0.
- Owner in OWN0 drops `m0_req` -> no grant that cycle, FSM returns to IDLE, and a waiting port 1 is granted the next cycle.
